// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter, read sequencer and flush control for a 16-entry FIFO
// Define FIFO_ARB_AFULL_EN to drive almost_full from AFULL_TH; otherwise almost_full is tied low.
module fifo_wr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 4,
  parameter int DEPTH    = 15,
  parameter int CW       = 5,
  parameter int AFULL_TH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  output logic                fifo_rd_en,
  input  logic [DW-1:0]       fifo_dout,
  input  logic                rd_req,
  output logic                rd_valid,
  output logic [DW-1:0]       rd_data,
  input  logic                flush,
  output logic                flush_done,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                empty,
  output logic                almost_full
);
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_TH);
  localparam logic [LW-1:0] LAST_INIT = LW'(N_REQ - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_next;
  logic [LW-1:0] last, last_next, win_idx, idx;
  logic          found;
  logic          can_wr;
  logic [CW-1:0] count_next;
  logic          rd_valid_next, flush_done_next;

  assign can_wr = (count < DEPTH_C);
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);

`ifdef FIFO_ARB_AFULL_EN
  assign almost_full = (count >= AFULL_C);
`else
  // Threshold has no effect in this build; the term is constant zero.
  assign almost_full = (count >= AFULL_C) & 1'b0;
`endif

  // Search starts just after the last winner and wraps, giving round-robin fairness.
  always_comb begin
    gnt     = '0;
    win_idx = last;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = LW'((int'(last) + k) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    if (found && can_wr && (state == RUN) && !rst)
      gnt[win_idx] = 1'b1;
  end

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) fifo_din = req_data[i*DW +: DW];
  end

  assign fifo_wr_en = |gnt;
  assign fifo_rd_en = (count != '0) && ((state == FLUSH) || rd_req);
  assign rd_data    = rd_valid ? fifo_dout : '0;

  always_comb begin
    state_next      = state;
    last_next       = last;
    count_next      = count;
    rd_valid_next   = 1'b0;
    flush_done_next = 1'b0;
    if (fifo_wr_en) last_next = win_idx;
    case ({fifo_wr_en, fifo_rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    case (state)
      RUN: begin
        rd_valid_next = fifo_rd_en;
        if (flush) state_next = FLUSH;
      end
      FLUSH: begin
        if (count == '0) begin
          state_next      = RUN;
          flush_done_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      last       <= LAST_INIT;
      count      <= '0;
      rd_valid   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      last       <= last_next;
      count      <= count_next;
      rd_valid   <= rd_valid_next;
      flush_done <= flush_done_next;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench: vector table, directed corner sequences, randomized run vs reference model
module tb_fifo_wr_arbiter;
  localparam int N_REQ = 4, DW = 4, DEPTH = 15, CW = 5, AFULL_TH = 12;
`ifdef FIFO_ARB_AFULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic [N_REQ-1:0]    gnt;
  logic                fifo_wr_en, fifo_rd_en;
  logic [DW-1:0]       fifo_din, rd_data;
  logic [DW-1:0]       fifo_dout;
  logic                rd_req = 1'b0, flush = 1'b0;
  logic                rd_valid, flush_done, full, empty, almost_full;
  logic [CW-1:0]       count;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH), .CW(CW), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .flush(flush), .flush_done(flush_done),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  // Stand-in for the 16-entry synchronous FIFO: registered read data.
  logic [DW-1:0] mem_q[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_rd_en && mem_q.size() > 0) fifo_dout <= mem_q.pop_front();
      if (fifo_wr_en && mem_q.size() < 16) mem_q.push_back(fifo_din);
    end
  end

  // Reference model state.
  int            m_count, m_last;
  bit            m_flush, m_rv, m_fd;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] sb[$];

  task automatic model_reset();
    m_count = 0; m_last = N_REQ - 1; m_flush = 0; m_rv = 0; m_fd = 0; m_rdata = '0;
    sb.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare current outputs with the model, then advance the model across the coming edge.
  task automatic model_step();
    int            win;
    bit            rd;
    logic [N_REQ-1:0] gnt_e;
    logic [DW-1:0] din_e, popped;
    win = -1;
    if (!m_flush && m_count < DEPTH)
      for (int k = 1; k <= N_REQ; k++) begin
        int i = (m_last + k) % N_REQ;
        if (win < 0 && req[i]) win = i;
      end
    gnt_e = '0; din_e = '0;
    if (win >= 0) begin
      gnt_e[win] = 1'b1;
      din_e = req_data[win*DW +: DW];
    end
    rd = (m_count > 0) && (m_flush || rd_req);
    check("m_gnt", gnt, gnt_e);
    check("m_wr_en", fifo_wr_en, win >= 0);
    check("m_din", fifo_din, din_e);
    check("m_rd_en", fifo_rd_en, rd);
    check("m_count", count, m_count);
    check("m_full", full, m_count == DEPTH);
    check("m_empty", empty, m_count == 0);
    check("m_afull", almost_full, AF_EN && (m_count >= AFULL_TH));
    check("m_rd_valid", rd_valid, m_rv);
    check("m_rd_data", rd_data, m_rv ? m_rdata : '0);
    check("m_flush_done", flush_done, m_fd);
    popped = '0;
    if (rd) popped = sb.pop_front();
    if (win >= 0) begin
      sb.push_back(din_e);
      m_last = win;
    end
    m_fd = m_flush && (m_count == 0);
    m_rv = rd && !m_flush;
    m_rdata = popped;
    if (m_flush) begin
      if (m_count == 0) m_flush = 0;
    end else if (flush) m_flush = 1;
    m_count = m_count + ((win >= 0) ? 1 : 0) - (rd ? 1 : 0);
  endtask

  task automatic cycle();
    @(negedge clk); model_step(); @(posedge clk); #1;
  endtask

  typedef struct {
    logic [N_REQ-1:0] req;
    logic             rd_req;
    logic [N_REQ-1:0] gnt;
    int               cnt;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, n;
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 0, 1'b0, 4'd0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b0, 4'd0};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 2, 1'b0, 4'd0};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 3, 1'b0, 4'd0};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 4, 1'b0, 4'd0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 5, 1'b0, 4'd0};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 4, 1'b1, 4'd1};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 3, 1'b1, 4'd2};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 2, 1'b1, 4'd3};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1, 1'b1, 4'd4};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b1, 4'd1};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 4'd0};

    // Reset state, with requests asserted during reset.
    model_reset();
    req = 4'b1111;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_flush_done", flush_done, 0);
    #4;
    rst = 1'b0;
    req = '0;

    // Round-robin table: data 1,2,3,4 on requesters 0..3.
    req_data = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int v = 0; v < 12; v++) begin
      req = tbl[v].req; rd_req = tbl[v].rd_req;
      @(negedge clk);
      check("tbl_gnt", gnt, tbl[v].gnt);
      check("tbl_count", count, tbl[v].cnt);
      check("tbl_rd_valid", rd_valid, tbl[v].rd_valid);
      check("tbl_rd_data", rd_data, tbl[v].rd_data);
      model_step();
      @(posedge clk); #1;
    end

    // Requester 2 fills to full; the 16th attempt is blocked.
    req = 4'b0100; rd_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      req_data[8 +: 4] = 4'(i);
      @(negedge clk);
      check("fill_gnt", gnt, 4'b0100);
      check("fill_count", count, i);
      check("fill_afull", almost_full, AF_EN && (i >= AFULL_TH));
      model_step();
      @(posedge clk); #1;
    end
    req_data[8 +: 4] = 4'd9;
    @(negedge clk);
    check("full_count", count, 15);
    check("full_flag", full, 1);
    check("full_gnt", gnt, 0);
    model_step();
    @(posedge clk); #1;
    rd_req = 1'b1;
    @(negedge clk);
    check("full_rw_gnt", gnt, 0);
    check("full_rw_rd_en", fifo_rd_en, 1);
    model_step();
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check("after_rd_count", count, 14);
    check("after_rd_gnt", gnt, 4'b0100);
    check("after_rd_data", rd_data, 0);
    model_step();
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    check("refill_count", count, 15);
    model_step();
    @(posedge clk); #1;

    // Drain, then read and write together at count 0.
    rd_req = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    req = 4'b0100; req_data[8 +: 4] = 4'd6;
    @(negedge clk);
    check("empty_rw_count", count, 0);
    check("empty_rw_rd_en", fifo_rd_en, 0);
    check("empty_rw_gnt", gnt, 4'b0100);
    model_step();
    @(posedge clk); #1;
    req = '0; rd_req = 1'b0;
    @(negedge clk);
    check("empty_rw_count1", count, 1);
    check("empty_rw_rd_valid", rd_valid, 0);
    model_step();
    @(posedge clk); #1;

    // Flush with 5 entries queued; requests and reads held throughout.
    req = 4'b0001;
    for (int i = 0; i < 4; i++) cycle();
    req = '0; flush = 1'b1;
    @(negedge clk);
    check("flush_start_count", count, 5);
    model_step();
    @(posedge clk); #1;
    flush = 1'b0; req = 4'b1111; rd_req = 1'b1;
    pulses = 0;
    for (n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n <= 6) begin
        check("flush_gnt", gnt, 0);
        check("flush_rd_en", fifo_rd_en, n <= 5);
      end
      check("flush_rd_valid", rd_valid, 0);
      check("flush_done_at", flush_done, n == 7);
      if (flush_done) pulses++;
      model_step();
      @(posedge clk); #1;
    end
    check("flush_pulses", pulses, 1);

    // Asynchronous reset mid-burst at count 7.
    req = 4'b1111; rd_req = 1'b0;
    n = 0;
    while (m_count < 8 && n < 20) begin cycle(); n++; end
    check("burst_reached", m_count, 8);
    req = '0; rd_req = 1'b1;
    cycle();
    req = 4'b1111; rd_req = 1'b1;
    #1;
    check("pre_rst_count", count, 7);
    check("pre_rst_rd_valid", rd_valid, 1);
    check("pre_rst_rd_en", fifo_rd_en, 1);
    rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_gnt", gnt, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_rd_data", rd_data, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", gnt, 4'b0001);
    model_step();
    @(posedge clk); #1;

    // almost_full crossing 11->12 and 12->11.
    req = 4'b0010;
    n = 0;
    while (m_count < 12 && n < 20) begin cycle(); n++; end
    req = '0; rd_req = 1'b1;
    @(negedge clk);
    check("af_at12_count", count, 12);
    check("af_at12", almost_full, AF_EN);
    model_step();
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check("af_at11", almost_full, 0);
    model_step();
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      req = N_REQ'($urandom_range(0, 15));
      req_data = N_REQ*DW'($urandom);
      rd_req = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      cycle();
    end
    req = '0; rd_req = 1'b0; flush = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
